conv16_feeder: RTL

- Upstream stage of the 16-row 3x3 convolution core; it drives that core's row, filter and enable inputs.
- Holds a 3x3 kernel, loaded through a small write port.
- Accepts a stream of 16-pixel image columns over a valid/ready handshake.
- Presents one column per accepted beat, with the matching kernel column on the filter outputs for the first three beats of each tile, then zero-column drain cycles and a done pulse.

---
 rtl/conv16_feeder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/conv16_feeder.sv
// Purpose : feeds the 16-row 3x3 convolution core with image columns and kernel taps, then drains and signals done.
// Latency : one cycle from an accepted column (s_valid & s_ready) to o_rows/o_f*/o_en.
// Backpr. : s_ready is high only in STREAM; stalled beats freeze o_rows/o_f* and drop o_en.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pulse that begins a tile (honoured only when idle)
//   w_we/w_addr/w_data    kernel write port, k[r][c] at r*3+c (0..8), idle only
//   s_valid/s_ready/s_data  16-pixel column stream, row k at [k*WIDTH +: WIDTH]
//   o_rows                registered column to the core, same packing as s_data
//   o_f1/o_f2/o_f3        kernel rows 0/1/2 tap for the current column step
//   o_en                  core step enable
//   busy                  tile in progress (any state but IDLE)
//   o_done                one-cycle pulse when the tile completes
module conv16_feeder #(
    parameter int WIDTH     = 8,
    parameter int TILE_COLS = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  w_we,
    input  logic [3:0]            w_addr,
    input  logic [WIDTH-1:0]      w_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [16*WIDTH-1:0]   s_data,
    output logic [16*WIDTH-1:0]   o_rows,
    output logic [WIDTH-1:0]      o_f1,
    output logic [WIDTH-1:0]      o_f2,
    output logic [WIDTH-1:0]      o_f3,
    output logic                  o_en,
    output logic                  busy,
    output logic                  o_done
);

    localparam int CW = $clog2(TILE_COLS + 1);
    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(TILE_COLS - 1);
    localparam logic [DW-1:0] LAST_DRN = DW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [DW-1:0]         drn_q, drn_d;
    logic [WIDTH-1:0]      kern_q [9];
    logic [WIDTH-1:0]      kern_d [9];
    logic [16*WIDTH-1:0]   rows_q, rows_d;
    logic [WIDTH-1:0]      f1_q, f1_d;
    logic [WIDTH-1:0]      f2_q, f2_d;
    logic [WIDTH-1:0]      f3_q, f3_d;
    logic                  en_q, en_d;
    logic                  beat;

    assign s_ready = (state_q == ST_STREAM);
    assign beat    = s_valid & s_ready;
    assign busy    = (state_q != ST_IDLE);
    assign o_done  = (state_q == ST_DONE);
    assign o_rows  = rows_q;
    assign o_f1    = f1_q;
    assign o_f2    = f2_q;
    assign o_f3    = f3_q;
    assign o_en    = en_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        drn_d   = drn_q;
        kern_d  = kern_q;
        rows_d  = rows_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        f3_d    = f3_q;
        en_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rows_d = '0;
                f1_d   = '0;
                f2_d   = '0;
                f3_d   = '0;
                col_d  = '0;
                drn_d  = '0;
                // Addresses 9..15 match no entry and are silently dropped.
                for (int i = 0; i < 9; i++) begin
                    if (w_we && (w_addr == 4'(i))) begin
                        kern_d[i] = w_data;
                    end
                end
                if (start) begin
                    state_d = ST_STREAM;
                end
            end

            ST_STREAM: begin
                // Without a beat everything holds and o_en falls (default).
                if (beat) begin
                    rows_d = s_data;
                    en_d   = 1'b1;
                    f1_d   = '0;
                    f2_d   = '0;
                    f3_d   = '0;
                    // Only the first three columns of a tile carry kernel taps.
                    for (int c = 0; c < 3; c++) begin
                        if (col_q == CW'(c)) begin
                            f1_d = kern_q[c];
                            f2_d = kern_q[3 + c];
                            f3_d = kern_q[6 + c];
                        end
                    end
                    col_d = col_q + CW'(1);
                    if (col_q == LAST_COL) begin
                        state_d = ST_DRAIN;
                        drn_d   = '0;
                    end
                end
            end

            ST_DRAIN: begin
                rows_d = '0;
                f1_d   = '0;
                f2_d   = '0;
                f3_d   = '0;
                en_d   = 1'b1;
                drn_d  = drn_q + DW'(1);
                if (drn_q == LAST_DRN) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                rows_d  = '0;
                f1_d    = '0;
                f2_d    = '0;
                f3_d    = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            drn_q   <= '0;
            for (int i = 0; i < 9; i++) begin
                kern_q[i] <= '0;
            end
            rows_q  <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
            f3_q    <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            drn_q   <= drn_d;
            for (int i = 0; i < 9; i++) begin
                kern_q[i] <= kern_d[i];
            end
            rows_q  <= rows_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            f3_q    <= f3_d;
            en_q    <= en_d;
        end
    end

endmodule
